ir_chirp_timer: RTL and testbench

Downstream execution stage for the TV-code sequencer: it consumes the sequencer's carrier (CTC) and delay interfaces and produces the IR LED drive. It times each on/off chirp in prescaled ticks and generates the modulated carrier from the frequency byte. It returns a busy flag that the sequencer's start/busy handshake depends on.

---
 rtl/ir_pkg.sv | 20 ++
 rtl/ir_carrier_gen.sv | 54 +++++
 rtl/ir_chirp_timer.sv | 119 +++++++++++
 tb/tb_ir_chirp_timer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared definitions for the IR chirp timer and the TV-code sequencer:
// timer state encoding and default widths/prescale shared by both blocks.
package ir_pkg;

    // Default width of a delay value, in prescaled ticks
    localparam int IR_DELAY_BITS = 16;

    // Default width of the carrier half-period value
    localparam int IR_CTC_BITS = 8;

    // Default clocks per delay tick (10 us at 12 MHz)
    localparam int IR_TICK_DIV = 120;

    // Delay timer states
    typedef enum logic {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } timer_state_e;

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier generator: latches the half-period value, runs the half-period
// counter and toggles the raw carrier at each half-period boundary.
module ir_carrier_gen
    import ir_pkg::*;
#(
    parameter int CTC_BITS = IR_CTC_BITS
) (
    input  logic                clock_in,
    input  logic                reset_n_in,
    input  logic                ctc_enable_in,
    input  logic                ctc_wr_strobe_in,
    input  logic [CTC_BITS-1:0] ctc_value_in,
    output logic                carrier_out
);

    logic [CTC_BITS-1:0] period_q, period_d;
    logic [CTC_BITS-1:0] half_q, half_d;
    logic                carrier_q, carrier_d;

    // Period latch and half-counter next state; a smaller new period is caught by the >= compare
    always_comb begin
        period_d  = period_q;
        half_d    = half_q;
        carrier_d = carrier_q;
        if (ctc_wr_strobe_in) begin
            period_d = ctc_value_in;
        end
        if (!ctc_enable_in) begin
            half_d    = '0;
            carrier_d = 1'b1;
        end else if (half_q >= period_q) begin
            half_d    = '0;
            carrier_d = ~carrier_q;
        end else begin
            half_d = half_q + CTC_BITS'(1);
        end
    end

    // Carrier state registers; carrier idles high so each burst opens with a full high half
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            period_q  <= '0;
            half_q    <= '0;
            carrier_q <= 1'b1;
        end else begin
            period_q  <= period_d;
            half_q    <= half_d;
            carrier_q <= carrier_d;
        end
    end

    assign carrier_out = carrier_q;

endmodule

// File: rtl/ir_chirp_timer.sv
// IR chirp timer: times each on/off chirp in prescaled ticks and drives the
// IR LED from the modulated carrier. Optional macro IR_ACTIVE_LOW_EN inverts
// ir_out (idle level 1) for sink-driven LEDs.
module ir_chirp_timer
    import ir_pkg::*;
#(
    parameter int DELAY_BITS = IR_DELAY_BITS,
    parameter int CTC_BITS   = IR_CTC_BITS,
    parameter int TICK_DIV   = IR_TICK_DIV
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic                  ctc_enable_in,
    input  logic                  ctc_forced_in,
    input  logic                  ctc_wr_strobe_in,
    input  logic [CTC_BITS-1:0]   ctc_value_in,
    input  logic                  delay_enable_in,
    input  logic                  delay_start_strobe_in,
    input  logic [DELAY_BITS-1:0] delay_value_in,
    output logic                  delay_busy_out,
    output logic                  ir_out
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK_DIV - 1);

`ifdef IR_ACTIVE_LOW_EN
    localparam logic IR_IDLE = 1'b1;
`else
    localparam logic IR_IDLE = 1'b0;
`endif

    timer_state_e          state_q, state_d;
    logic [DELAY_BITS-1:0] count_q, count_d;
    logic [PRE_W-1:0]      prescaler_q, prescaler_d;
    logic                  busy_q, busy_d;
    logic                  ir_q, ir_d;
    logic                  carrier;

    ir_carrier_gen #(
        .CTC_BITS(CTC_BITS)
    ) u_carrier (
        .clock_in        (clock_in),
        .reset_n_in      (reset_n_in),
        .ctc_enable_in   (ctc_enable_in),
        .ctc_wr_strobe_in(ctc_wr_strobe_in),
        .ctc_value_in    (ctc_value_in),
        .carrier_out     (carrier)
    );

    // Delay FSM next state; the last tick exits on the wrap that takes count to zero
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        prescaler_d = prescaler_q;
        case (state_q)
            T_IDLE: begin
                if (delay_enable_in && delay_start_strobe_in) begin
                    state_d     = T_RUN;
                    count_d     = delay_value_in;
                    prescaler_d = '0;
                end
            end
            T_RUN: begin
                if (!delay_enable_in) begin
                    state_d     = T_IDLE;
                    count_d     = '0;
                    prescaler_d = '0;
                end else if (count_q == '0) begin
                    state_d     = T_IDLE;
                    prescaler_d = '0;
                end else if (prescaler_q == TICK_LAST) begin
                    prescaler_d = '0;
                    count_d     = count_q - DELAY_BITS'(1);
                    if (count_q == DELAY_BITS'(1)) begin
                        state_d = T_IDLE;
                    end
                end else begin
                    prescaler_d = prescaler_q + PRE_W'(1);
                end
            end
            default: begin
                state_d     = T_IDLE;
                count_d     = '0;
                prescaler_d = '0;
            end
        endcase
    end

    // Output decode; forced drive wins over the modulated carrier
    always_comb begin
        busy_d = (state_d == T_RUN);
        ir_d   = ctc_forced_in ? 1'b1 : (ctc_enable_in ? carrier : 1'b0);
`ifdef IR_ACTIVE_LOW_EN
        ir_d   = ~ir_d;
`endif
    end

    // Timer state and registered outputs
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q     <= T_IDLE;
            count_q     <= '0;
            prescaler_q <= '0;
            busy_q      <= 1'b0;
            ir_q        <= IR_IDLE;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            prescaler_q <= prescaler_d;
            busy_q      <= busy_d;
            ir_q        <= ir_d;
        end
    end

    assign delay_busy_out = busy_q;
    assign ir_out         = ir_q;

endmodule

// File: tb/tb_ir_chirp_timer.sv
// Testbench for ir_chirp_timer: directed stimulus with a scoreboard queue of
// expected outputs, popped and compared by a monitor on each falling edge.
module tb_ir_chirp_timer;

    localparam int TD = 4;

`ifdef IR_ACTIVE_LOW_EN
    localparam logic IR_INV = 1'b1;
`else
    localparam logic IR_INV = 1'b0;
`endif

    logic        clock_in = 1'b0;
    logic        reset_n_in;
    logic        ctc_enable_in;
    logic        ctc_forced_in;
    logic        ctc_wr_strobe_in;
    logic [7:0]  ctc_value_in;
    logic        delay_enable_in;
    logic        delay_start_strobe_in;
    logic [15:0] delay_value_in;
    logic        delay_busy_out;
    logic        ir_out;

    typedef struct {
        logic  chk_busy;
        logic  exp_busy;
        logic  chk_ir;
        logic  exp_ir;
        string name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    ir_chirp_timer #(
        .DELAY_BITS(16),
        .CTC_BITS  (8),
        .TICK_DIV  (TD)
    ) dut (
        .clock_in             (clock_in),
        .reset_n_in           (reset_n_in),
        .ctc_enable_in        (ctc_enable_in),
        .ctc_forced_in        (ctc_forced_in),
        .ctc_wr_strobe_in     (ctc_wr_strobe_in),
        .ctc_value_in         (ctc_value_in),
        .delay_enable_in      (delay_enable_in),
        .delay_start_strobe_in(delay_start_strobe_in),
        .delay_value_in       (delay_value_in),
        .delay_busy_out       (delay_busy_out),
        .ir_out               (ir_out)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clock_in = ~clock_in;

    // Monitor: pop one expectation per falling edge and compare the outputs
    always @(negedge clock_in) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            if (mon_e.chk_busy) begin
                n_compared++;
                if (delay_busy_out !== mon_e.exp_busy) begin
                    n_mismatched++;
                    $display("[TB] FAIL %s busy: got %b expected %b", mon_e.name, delay_busy_out, mon_e.exp_busy);
                end
            end
            if (mon_e.chk_ir) begin
                n_compared++;
                if (ir_out !== (mon_e.exp_ir ^ IR_INV)) begin
                    n_mismatched++;
                    $display("[TB] FAIL %s ir: got %b expected %b", mon_e.name, ir_out, mon_e.exp_ir ^ IR_INV);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic den, input logic dstart, input logic [15:0] dval,
                                 input logic cen, input logic cforced);
        delay_enable_in       = den;
        delay_start_strobe_in = dstart;
        delay_value_in        = dval;
        ctc_enable_in         = cen;
        ctc_forced_in         = cforced;
    endtask

    // Queue the outputs expected after the next rising edge, then advance one cycle
    task automatic checkOutput(input string name, input logic cb, input logic eb,
                               input logic ci, input logic ei);
        exp_t e;
        e.chk_busy = cb;
        e.exp_busy = eb;
        e.chk_ir   = ci;
        e.exp_ir   = ei;
        e.name     = name;
        sb_q.push_back(e);
        @(negedge clock_in);
        #1;
    endtask

    // Assert reset between a rising and a falling edge so only the async path can clear outputs
    task automatic resetPulse(input string name);
        exp_t e;
        @(posedge clock_in);
        #2;
        reset_n_in = 1'b0;
        e.chk_busy = 1'b1;
        e.exp_busy = 1'b0;
        e.chk_ir   = 1'b1;
        e.exp_ir   = 1'b0;
        e.name     = name;
        sb_q.push_back(e);
        @(negedge clock_in);
        #1;
        delay_start_strobe_in = 1'b0;
        ctc_enable_in         = 1'b0;
        reset_n_in            = 1'b1;
    endtask

    initial begin
        reset_n_in       = 1'b0;
        ctc_wr_strobe_in = 1'b0;
        ctc_value_in     = 8'd0;
        applyStimulus(1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        @(negedge clock_in);
        #1;
        checkOutput("reset_state", 1'b1, 1'b0, 1'b1, 1'b0);
        reset_n_in = 1'b1;

        $display("[TB] delay 3 ticks, strobe held 2 cycles");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, i < 2, 16'd3, 1'b0, 1'b0);
            checkOutput($sformatf("t1_busy[%0d]", i), 1'b1, i < 12, 1'b1, 1'b0);
        end

        $display("[TB] delay value 0");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, i < 2, 16'd0, 1'b0, 1'b0);
            checkOutput($sformatf("t2_busy[%0d]", i), 1'b1, i == 0, 1'b0, 1'b0);
        end

        $display("[TB] carrier half-period 2");
        ctc_wr_strobe_in = 1'b1;
        ctc_value_in     = 8'd2;
        applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
        checkOutput("t3_write", 1'b1, 1'b0, 1'b1, 1'b0);
        ctc_wr_strobe_in = 1'b0;
        ctc_value_in     = 8'd0;
        for (int j = 0; j < 24; j++) begin
            applyStimulus(1'b1, 1'b0, 16'd0, 1'b1, 1'b0);
            checkOutput($sformatf("t3_ir[%0d]", j), 1'b0, 1'b0, 1'b1, ((j / 3) % 2) == 0);
        end
        applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
        checkOutput("t3_off", 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] forced drive");
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
            checkOutput($sformatf("t4_forced[%0d]", j), 1'b0, 1'b0, 1'b1, 1'b1);
        end
        for (int j = 0; j < 6; j++) begin
            applyStimulus(1'b1, 1'b0, 16'd0, 1'b1, 1'b1);
            checkOutput($sformatf("t4_both[%0d]", j), 1'b0, 1'b0, 1'b1, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
        checkOutput("t4_release", 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] abort by delay_enable low, then full restart");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, i < 2, 16'd100, 1'b0, 1'b0);
            checkOutput($sformatf("t5_run[%0d]", i), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 16'd100, 1'b0, 1'b0);
        checkOutput("t5_abort", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 401; i++) begin
            applyStimulus(1'b1, i < 2, 16'd100, 1'b0, 1'b0);
            checkOutput($sformatf("t5_restart[%0d]", i), 1'b1, i < 400, 1'b0, 1'b0);
        end

        $display("[TB] async reset mid-delay and mid-carrier");
        for (int j = 0; j < 2; j++) begin
            applyStimulus(1'b1, 1'b1, 16'd100, 1'b1, 1'b0);
            checkOutput($sformatf("t6_pre[%0d]", j), 1'b1, 1'b1, 1'b1, 1'b1);
        end
        resetPulse("t6_async_reset");
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b1, 1'b0, 16'd100, 1'b0, 1'b0);
            checkOutput($sformatf("t6_no_start[%0d]", j), 1'b1, 1'b0, 1'b1, 1'b0);
        end
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b1, 1'b0, 16'd0, 1'b1, 1'b0);
            checkOutput($sformatf("t6_period0[%0d]", j), 1'b0, 1'b0, 1'b1, (j % 2) == 0);
        end

        applyStimulus(1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        @(negedge clock_in);
        #1;
        n_compared++;
        if (sb_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
